// File: rtl/tc_sram_rd_addr_gen.sv
// rtl/tc_sram_rd_addr_gen.sv - multi-bank SRAM read address generator for tensor-core operand buffers
module tc_sram_rd_addr_gen #(
  parameter int ADDR_W    = 4,
  parameter int NUM_BANKS = 2,
  parameter int PASS_W    = 3,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_type,
  input  logic [1:0]           cfg_rc,
  input  logic                 abort,
  input  logic                 fill_done,
  input  logic [BANK_W-1:0]    fill_bank,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [BANK_W-1:0]    rd_bank,
  output logic                 rd_last,
  output logic                 bank_release,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state;
  logic [ADDR_W-1:0]    limit;
  logic [PASS_W-1:0]    passes_m1;
  logic [ADDR_W-1:0]    word;
  logic [ADDR_W-1:0]    word_inc;
  logic [PASS_W-1:0]    pass;
  logic [BANK_W-1:0]    ptr;
  logic [ADDR_W-1:0]    cfg_limit;
  logic [PASS_W-1:0]    cfg_passes_m1;
  logic                 cfg_accept;
  logic                 release_now;
  logic                 fill_err;
  logic [NUM_BANKS-1:0] fill_set;
  logic [NUM_BANKS-1:0] rel_clr;

  assign cfg_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign cfg_accept  = cfg_valid && cfg_ready;
  assign rd_addr     = word;
  assign word_inc    = word + ADDR_W'(1);
  // Last accepted word of a pass frees the bank currently being read.
  assign release_now = (state == S_READ) && rd_valid && rd_ready && (word == limit);

  // Decode element type into the last word index of one pass.
  always_comb begin
    cfg_limit = ADDR_W'(1);
    case (cfg_type)
      2'd0:    cfg_limit = ADDR_W'(15);
      2'd1:    cfg_limit = ADDR_W'(7);
      2'd2:    cfg_limit = ADDR_W'(3);
      default: cfg_limit = ADDR_W'(1);
    endcase
  end

  // Decode row/column shape into pass count minus one (rc=11 never reaches a job).
  always_comb begin
    cfg_passes_m1 = '0;
    case (cfg_rc)
      2'd0:    cfg_passes_m1 = PASS_W'(3);
      2'd1:    cfg_passes_m1 = PASS_W'(1);
      default: cfg_passes_m1 = '0;
    endcase
  end

  // Per-bank fill and release strobes.
  always_comb begin
    fill_set = '0;
    rel_clr  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      fill_set[i] = fill_done && (fill_bank == BANK_W'(i));
      rel_clr[i]  = release_now && (ptr == BANK_W'(i));
    end
  end

  // A fill into a bank that is full and not being released this cycle is an overrun.
  assign fill_err = |(fill_set & bank_full & ~rel_clr);

  // Bank occupancy flags; a fill landing with the release of the same bank wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
    end else if (abort) begin
      bank_full <= '0;
    end else begin
      bank_full <= fill_set | (bank_full & ~rel_clr);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      if (cfg_accept && !abort && (cfg_rc == 2'b11)) err[0] <= 1'b1;
      if (fill_err) err[1] <= 1'b1;
    end
  end

  // Job sequencer: wait for bank, stream words, release, advance ring pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      limit        <= '0;
      passes_m1    <= '0;
      word         <= '0;
      pass         <= '0;
      ptr          <= '0;
      rd_valid     <= 1'b0;
      rd_bank      <= '0;
      rd_last      <= 1'b0;
      bank_release <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      limit        <= '0;
      passes_m1    <= '0;
      word         <= '0;
      pass         <= '0;
      ptr          <= '0;
      rd_valid     <= 1'b0;
      rd_bank      <= '0;
      rd_last      <= 1'b0;
      bank_release <= 1'b0;
      done         <= 1'b0;
    end else begin
      bank_release <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid && (cfg_rc != 2'b11)) begin
            limit     <= cfg_limit;
            passes_m1 <= cfg_passes_m1;
            word      <= '0;
            pass      <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bank_full[ptr]) begin
            state    <= S_READ;
            rd_valid <= 1'b1;
            rd_bank  <= ptr;
            word     <= '0;
            rd_last  <= (limit == '0) && (pass == passes_m1);
          end
        end
        S_READ: begin
          if (rd_valid && rd_ready) begin
            if (word == limit) begin
              word         <= '0;
              rd_valid     <= 1'b0;
              rd_last      <= 1'b0;
              bank_release <= 1'b1;
              ptr          <= ptr + BANK_W'(1);
              if (pass == passes_m1) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                pass  <= pass + PASS_W'(1);
                state <= S_WAIT;
              end
            end else begin
              word    <= word_inc;
              rd_last <= (word_inc == limit) && (pass == passes_m1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_sram_rd_addr_gen.sv
// tb/tb_tc_sram_rd_addr_gen.sv - self-checking bench for tc_sram_rd_addr_gen
module tb_tc_sram_rd_addr_gen;
  localparam int ADDR_W    = 4;
  localparam int NUM_BANKS = 2;
  localparam int PASS_W    = 3;
  localparam int BANK_W    = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_type;
  logic [1:0]           cfg_rc;
  logic                 abort;
  logic                 fill_done;
  logic [BANK_W-1:0]    fill_bank;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [ADDR_W-1:0]    rd_addr;
  logic [BANK_W-1:0]    rd_bank;
  logic                 rd_last;
  logic                 bank_release;
  logic [NUM_BANKS-1:0] bank_full;
  logic                 busy;
  logic                 done;
  logic [1:0]           err;

  tc_sram_rd_addr_gen #(.ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_type(cfg_type), .cfg_rc(cfg_rc), .abort(abort), .fill_done(fill_done),
    .fill_bank(fill_bank), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .rd_last(rd_last), .bank_release(bank_release),
    .bank_full(bank_full), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic              last;
    logic              eop;
  } rd_exp_t;

  typedef struct {
    logic [1:0] typ;
    logic [1:0] rc;
    int         mode;
    int         exp_reads;
    int         exp_rel;
    string      name;
  } job_t;

  rd_exp_t sb_q[$];
  job_t    jobs[5];

  int n_check = 0;
  int n_pass  = 0;
  int rd_cnt = 0, rel_cnt = 0, done_cnt = 0, cyc = 0;
  int ready_mode = 0, refill_budget = 0, tb_ptr = 0;
  bit refill_pend = 0;
  logic [BANK_W-1:0] refill_bank = '0;
  bit prev_stall = 0, exp_done_next = 0, exp_rel_next = 0;
  logic [ADDR_W+BANK_W:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input int act, input int exp);
    n_check++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int rc_passes(input logic [1:0] rc);
    return (rc == 2'd0) ? 4 : (rc == 2'd1) ? 2 : 1;
  endfunction

  // Output observer, called once per cycle at the falling edge.
  task automatic monitor();
    rd_exp_t e;
    if (!rst_n) begin
      prev_stall = 0; exp_done_next = 0; exp_rel_next = 0;
      return;
    end
    if (exp_done_next || done) check("done_pulse", done, exp_done_next);
    if (exp_rel_next || bank_release) check("release_pulse", bank_release, exp_rel_next);
    if (bank_release) begin
      rel_cnt++;
      if (refill_budget > 0) begin
        refill_budget--; refill_pend = 1; refill_bank = rd_bank;
      end
    end
    if (done) done_cnt++;
    exp_done_next = 0; exp_rel_next = 0;
    if (prev_stall) begin
      check("hold_valid", rd_valid, 1);
      check("hold_data", {rd_addr, rd_bank, rd_last}, prev_word);
    end
    if (rd_valid && rd_ready && !abort) begin
      rd_cnt++;
      if (sb_q.size() == 0) fail("unexpected_read", rd_cnt, 0);
      else begin
        e = sb_q.pop_front();
        check("rd_word", {rd_addr, rd_bank, rd_last}, {e.addr, e.bank, e.last});
        exp_rel_next  = e.eop;
        exp_done_next = e.last;
      end
    end
    prev_stall = rd_valid && !rd_ready && !abort;
    prev_word  = {rd_addr, rd_bank, rd_last};
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    cfg_valid = 0; fill_done = 0; abort = 0;
    if (refill_pend) begin
      fill_done = 1; fill_bank = refill_bank; refill_pend = 0;
    end
    case (ready_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = (cyc % 2 == 1);
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic fill(input int b);
    fill_done = 1; fill_bank = BANK_W'(b);
    tick();
  endtask

  task automatic push_job(input logic [1:0] typ, input logic [1:0] rc);
    int words, np;
    rd_exp_t e;
    words = (typ == 2'd0) ? 16 : (typ == 2'd1) ? 8 : (typ == 2'd2) ? 4 : 2;
    np = rc_passes(rc);
    for (int p = 0; p < np; p++) begin
      for (int a = 0; a < words; a++) begin
        e.addr = ADDR_W'(a);
        e.bank = BANK_W'((tb_ptr + p) % NUM_BANKS);
        e.last = (p == np - 1) && (a == words - 1);
        e.eop  = (a == words - 1);
        sb_q.push_back(e);
      end
    end
    tb_ptr = (tb_ptr + np) % NUM_BANKS;
  endtask

  task automatic start_job(input logic [1:0] typ, input logic [1:0] rc);
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1; cfg_type = typ; cfg_rc = rc;
    tick();
    check("busy_after_cfg", busy, 1);
  endtask

  task automatic run_until_done(input int max_cycles);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < max_cycles) begin
      tick(); n++;
    end
    if (done_cnt == d0) fail("job_timeout", n, max_cycles);
    check("idle_after_done", cfg_ready, 1);
  endtask

  task automatic wait_addr(input int bank, input int addr, input int max_cycles);
    int n;
    n = 0;
    while (!(rd_valid && rd_bank == BANK_W'(bank) && rd_addr == ADDR_W'(addr)) && n < max_cycles) begin
      tick(); n++;
    end
    if (n >= max_cycles) fail("wait_addr_timeout", n, max_cycles);
  endtask

  initial begin
    int r0, l0, d0, b, np;
    jobs[0] = '{2'd0, 2'd1, 0, 32, 2, "fp32_rc01"};
    jobs[1] = '{2'd3, 2'd0, 0, 8, 4, "int4_rc00"};
    jobs[2] = '{2'd2, 2'd2, 2, 4, 1, "int8_rc10_rand"};
    jobs[3] = '{2'd1, 2'd0, 1, 32, 4, "fp16_rc00_toggle"};
    jobs[4] = '{2'd3, 2'd1, 2, 4, 2, "int4_rc01_rand"};

    rst_n = 0; cfg_valid = 0; cfg_type = 0; cfg_rc = 0; abort = 0;
    fill_done = 0; fill_bank = 0; rd_ready = 0;
    #1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_outputs", {rd_valid, rd_addr, rd_bank, rd_last, bank_release, busy, done}, 0);
    check("rst_full_err", {bank_full, err}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Table-driven jobs (T1, T2 and variants).
    for (int j = 0; j < 5; j++) begin
      np = rc_passes(jobs[j].rc);
      ready_mode = 0;
      fill(tb_ptr);
      if (np > 1) fill((tb_ptr + 1) % NUM_BANKS);
      refill_budget = (np > 2) ? np - 2 : 0;
      r0 = rd_cnt; l0 = rel_cnt; d0 = done_cnt;
      ready_mode = jobs[j].mode;
      push_job(jobs[j].typ, jobs[j].rc);
      start_job(jobs[j].typ, jobs[j].rc);
      run_until_done(400);
      check({jobs[j].name, "_reads"}, rd_cnt - r0, jobs[j].exp_reads);
      check({jobs[j].name, "_releases"}, rel_cnt - l0, jobs[j].exp_rel);
      check({jobs[j].name, "_done"}, done_cnt - d0, 1);
      check({jobs[j].name, "_sb_empty"}, sb_q.size(), 0);
      check({jobs[j].name, "_full_err"}, {bank_full, err}, 0);
    end

    // T3: late fill, toggling ready.
    ready_mode = 1;
    b = tb_ptr;
    r0 = rd_cnt;
    push_job(2'd1, 2'd2);
    start_job(2'd1, 2'd2);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_wait_no_valid", rd_valid, 0);
    end
    check("t3_wait_busy", busy, 1);
    fill(b);
    run_until_done(100);
    check("t3_reads", rd_cnt - r0, 8);

    // T5: fill lands on the release cycle of the same bank.
    ready_mode = 0;
    b = tb_ptr;
    fill(b);
    push_job(2'd3, 2'd2);
    start_job(2'd3, 2'd2);
    wait_addr(b, 1, 20);
    fill_done = 1; fill_bank = BANK_W'(b);
    tick();
    check("t5_full_after", bank_full[b], 1);
    check("t5_err", err, 0);
    run_until_done(5);

    // T6a: abort mid-read of pass 0.
    fill(tb_ptr);
    b = tb_ptr;
    push_job(2'd0, 2'd1);
    start_job(2'd0, 2'd1);
    wait_addr(b, 5, 40);
    abort = 1;
    tick();
    sb_q.delete();
    tb_ptr = 0;
    check("abort_rd_valid", rd_valid, 0);
    check("abort_idle", {cfg_ready, busy}, 2'b10);
    check("abort_full", bank_full, 0);
    d0 = done_cnt; l0 = rel_cnt;
    for (int k = 0; k < 3; k++) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_release", rel_cnt - l0, 0);
    check("abort_err_kept", err, 0);

    // T4: illegal rc and fill overrun.
    d0 = done_cnt;
    cfg_valid = 1; cfg_type = 2'd0; cfg_rc = 2'd3;
    tick();
    check("t4_err0", err, 2'b01);
    check("t4_cfg_ready", cfg_ready, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_no_done", done_cnt - d0, 0);
    fill(0);
    fill(0);
    check("t4_err_both", err, 2'b11);
    check("t4_full", bank_full, 2'b01);

    // T6b: async reset in pass 1, then fresh job from bank 0.
    fill(1);
    push_job(2'd0, 2'd1);
    start_job(2'd0, 2'd1);
    wait_addr(1, 5, 80);
    #2 rst_n = 0;
    #1;
    check("areset_rd", {rd_valid, rd_addr, rd_bank, rd_last}, 0);
    check("areset_pulses", {bank_release, done, busy}, 0);
    check("areset_full_err", {bank_full, err}, 0);
    check("areset_cfg_ready", cfg_ready, 1);
    sb_q.delete();
    tb_ptr = 0;
    tick();
    tick();
    rst_n = 1;
    r0 = rd_cnt;
    fill(0);
    push_job(2'd0, 2'd2);
    start_job(2'd0, 2'd2);
    run_until_done(100);
    check("post_reset_reads", rd_cnt - r0, 16);
    check("post_reset_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end
endmodule
